// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler: tracks ready slots, counts the time quantum in retired
// instructions and sequences context save/restore with the PC and register file.
module quantum_scheduler #(
    parameter int NPROC           = 8,
    parameter int PID_W           = 3,
    parameter int QUANTUM_W       = 16,
    parameter int DEFAULT_QUANTUM = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [QUANTUM_W-1:0] quantum_val,
    input  logic                 instr_retired,
    input  logic                 proc_create,
    input  logic [PID_W-1:0]     create_pid,
    input  logic                 proc_kill,
    input  logic                 yield,
    input  logic                 save_done,
    input  logic                 restore_done,
    output logic [NPROC-1:0]     ready_mask,
    output logic [PID_W-1:0]     cur_pid,
    output logic                 cur_valid,
    output logic [PID_W-1:0]     next_pid,
    output logic                 ctx_save,
    output logic                 ctx_restore,
    output logic                 return_os
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_RESTORE,
        S_RUN,
        S_SAVE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NPROC-1:0]     r_ready;
    logic [NPROC-1:0]     w_ready_nxt;
    logic [PID_W-1:0]     r_cur_pid;
    logic [PID_W-1:0]     r_next_pid;
    logic [QUANTUM_W-1:0] r_cnt;
    logic                 r_save_to_idle;

    logic                 w_hit;
    logic [PID_W-1:0]     w_hit_pid;
    logic [PID_W-1:0]     w_idx;
    logic [NPROC-1:0]     w_cur_onehot;
    logic                 w_only_self;
    logic                 w_expire;
    logic                 w_rotate;
    logic [QUANTUM_W-1:0] w_load_val;

    assign w_cur_onehot = {{(NPROC-1){1'b0}}, 1'b1} << r_cur_pid;
    assign w_only_self  = (r_ready == w_cur_onehot);
    assign w_expire     = instr_retired && (r_cnt == QUANTUM_W'(1));
    assign w_rotate     = w_expire || yield;
    assign w_load_val   = (quantum_val == '0) ? QUANTUM_W'(DEFAULT_QUANTUM) : quantum_val;

    // Offsets 1..NPROC from cur_pid; offset NPROC wraps to cur_pid itself, checked last.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_pid = '0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= NPROC; i++) begin
            w_idx = r_cur_pid + PID_W'(i);
            if (!w_hit && r_ready[w_idx]) begin
                w_hit     = 1'b1;
                w_hit_pid = w_idx;
            end
        end
    end

    always_comb begin
        w_ready_nxt = r_ready;
        if (r_state == S_RUN && proc_kill)
            w_ready_nxt[r_cur_pid] = 1'b0;
        if (proc_create)
            w_ready_nxt[create_pid] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable && r_ready != '0) w_state_nxt = S_PICK;
            S_PICK:    w_state_nxt = w_hit ? S_RESTORE : S_IDLE;
            S_RESTORE: if (restore_done) w_state_nxt = S_RUN;
            S_RUN: begin
                if (proc_kill)
                    w_state_nxt = S_PICK;
                else if (!enable)
                    w_state_nxt = S_SAVE;
                else if (w_rotate && !w_only_self)
                    w_state_nxt = S_SAVE;
            end
            S_SAVE:    if (save_done) w_state_nxt = r_save_to_idle ? S_IDLE : S_PICK;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cur_valid   = (r_state == S_RUN);
        ctx_save    = (r_state == S_SAVE);
        ctx_restore = (r_state == S_RESTORE);
        return_os   = (r_state == S_PICK) && !w_hit;
    end

    assign ready_mask = r_ready;
    assign cur_pid    = r_cur_pid;
    assign next_pid   = r_next_pid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready        <= '0;
            r_cur_pid      <= '0;
            r_next_pid     <= '0;
            r_cnt          <= '0;
            r_save_to_idle <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            case (r_state)
                S_PICK: begin
                    if (w_hit)
                        r_next_pid <= w_hit_pid;
                end
                S_RESTORE: begin
                    if (restore_done) begin
                        r_cur_pid <= r_next_pid;
                        r_cnt     <= w_load_val;
                    end
                end
                S_RUN: begin
                    r_save_to_idle <= !enable;
                    // The counter holds at 1 rather than wrapping; expiry is decided on 1.
                    if (!proc_kill && enable) begin
                        if (w_rotate && w_only_self)
                            r_cnt <= w_load_val;
                        else if (instr_retired && r_cnt > QUANTUM_W'(1))
                            r_cnt <= r_cnt - QUANTUM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
